// File: rtl/gbsha_ttfir_param_core.sv
// Direct-form FIR with runtime-loadable coefficients, valid/ready input handshake,
// saturating scaled output beat and an optional second beat carrying the accumulator LSBs.
module gbsha_ttfir_param_core #(
  parameter int N_TAPS = 4,
  parameter int BW_IN  = 6,
  parameter int BW_OUT = 8,
  parameter int SHIFT  = 6
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     coef_load,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [BW_IN-1:0]  data_in,
  output logic signed [BW_OUT-1:0] y_out,
  output logic                     out_valid,
  output logic                     out_lsb,
  output logic                     sat,
  output logic                     loaded
);

  localparam int BW_PROD = 2 * BW_IN;
  localparam int BW_ACC  = 2 * BW_IN + $clog2(N_TAPS);
  localparam int CNT_W   = $clog2(N_TAPS + 1);

  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(N_TAPS);
  localparam logic signed [BW_ACC-1:0] Y_MAX    = BW_ACC'((2 ** (BW_OUT - 1)) - 1);
  localparam logic signed [BW_ACC-1:0] Y_MIN    = BW_ACC'(-(2 ** (BW_OUT - 1)));

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_LSB
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         load_cnt_q, load_cnt_d;
  logic                     lsb_mode_q, lsb_mode_d;
  logic signed [BW_IN-1:0]  coef_q [N_TAPS];
  logic signed [BW_IN-1:0]  coef_d [N_TAPS];
  logic signed [BW_IN-1:0]  x_q    [N_TAPS-1];
  logic signed [BW_IN-1:0]  x_d    [N_TAPS-1];
  logic [BW_OUT-1:0]        acc_lsb_q, acc_lsb_d;
  logic signed [BW_OUT-1:0] y_q, y_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_lsb_q, out_lsb_d;
  logic                     sat_q, sat_d;

  logic                     accept;
  logic signed [BW_IN-1:0]  samp [N_TAPS];
  logic signed [BW_PROD-1:0] prod [N_TAPS];
  logic signed [BW_ACC-1:0] acc_sum;
  logic signed [BW_ACC-1:0] acc_shr;
  logic                     clip;
  logic signed [BW_OUT-1:0] y_scaled;

  assign in_ready  = (state_q != S_LSB);
  assign loaded    = (state_q == S_RUN) || (state_q == S_LSB);
  assign accept    = in_valid & in_ready;
  assign y_out     = y_q;
  assign out_valid = out_valid_q;
  assign out_lsb   = out_lsb_q;
  assign sat       = sat_q;

  // The tap sum is sized so that no combination of inputs can overflow it.
  always_comb begin
    samp[0] = data_in;
    for (int i = 1; i < N_TAPS; i++) samp[i] = x_q[i-1];
    acc_sum = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      prod[i] = BW_PROD'(coef_q[i]) * BW_PROD'(samp[i]);
      acc_sum = acc_sum + BW_ACC'(prod[i]);
    end
    acc_shr = acc_sum >>> SHIFT;
    clip    = (acc_shr > Y_MAX) || (acc_shr < Y_MIN);
    if (acc_shr > Y_MAX)      y_scaled = Y_MAX[BW_OUT-1:0];
    else if (acc_shr < Y_MIN) y_scaled = Y_MIN[BW_OUT-1:0];
    else                      y_scaled = acc_shr[BW_OUT-1:0];
  end

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    lsb_mode_d  = lsb_mode_q;
    coef_d      = coef_q;
    x_d         = x_q;
    acc_lsb_d   = acc_lsb_q;
    y_d         = y_q;
    out_valid_d = 1'b0;
    out_lsb_d   = out_lsb_q;
    sat_d       = sat_q;

    if (coef_load) begin
      state_d    = S_LOAD;
      load_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (accept) begin
            if (load_cnt_q == '0) begin
              lsb_mode_d = data_in[0];
              load_cnt_d = CNT_W'(1);
            end else begin
              for (int i = N_TAPS - 1; i > 0; i--) coef_d[i] = coef_q[i-1];
              coef_d[0] = data_in;
              if (load_cnt_q == CNT_LAST) begin
                for (int i = 0; i < N_TAPS - 1; i++) x_d[i] = '0;
                load_cnt_d = '0;
                state_d    = S_RUN;
              end else begin
                load_cnt_d = load_cnt_q + CNT_W'(1);
              end
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            x_d[0] = data_in;
            for (int i = 1; i < N_TAPS - 1; i++) x_d[i] = x_q[i-1];
            acc_lsb_d   = acc_sum[BW_OUT-1:0];
            y_d         = y_scaled;
            out_valid_d = 1'b1;
            out_lsb_d   = 1'b0;
            sat_d       = clip;
            if (lsb_mode_q) state_d = S_LSB;
          end
        end
        S_LSB: begin
          y_d         = $signed(acc_lsb_q);
          out_valid_d = 1'b1;
          out_lsb_d   = 1'b1;
          sat_d       = 1'b0;
          state_d     = S_RUN;
        end
        default: state_d = S_LOAD;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_LOAD;
      load_cnt_q  <= '0;
      lsb_mode_q  <= 1'b0;
      acc_lsb_q   <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      out_lsb_q   <= 1'b0;
      sat_q       <= 1'b0;
      // NOTE: coefficient and delay registers are flops, not RAM, so they can and must be cleared here.
      for (int i = 0; i < N_TAPS; i++)     coef_q[i] <= '0;
      for (int i = 0; i < N_TAPS - 1; i++) x_q[i]    <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      lsb_mode_q  <= lsb_mode_d;
      coef_q      <= coef_d;
      x_q         <= x_d;
      acc_lsb_q   <= acc_lsb_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      out_lsb_q   <= out_lsb_d;
      sat_q       <= sat_d;
    end
  end

endmodule

// File: tb/tb_gbsha_ttfir_param_core.sv
// Scoreboard bench: three cores (SHIFT 6/4/0) share one stimulus stream; a queue-based reference
// model predicts each output beat and a negedge monitor compares all three instances.
module tb_gbsha_ttfir_param_core;

  localparam int N = 4;
  localparam int SHIFTS [3] = '{6, 4, 0};

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              coef_load = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [5:0] data_in = '0;
  logic              in_ready  [3];
  logic              out_valid [3];
  logic              out_lsb   [3];
  logic              sat       [3];
  logic              loaded    [3];
  logic signed [7:0] y_out     [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gbsha_ttfir_param_core #(
      .N_TAPS(4), .BW_IN(6), .BW_OUT(8), .SHIFT(g == 0 ? 6 : (g == 1 ? 4 : 0))
    ) u_dut (
      .clk(clk), .reset_n(reset_n), .coef_load(coef_load), .in_valid(in_valid),
      .in_ready(in_ready[g]), .data_in(data_in), .y_out(y_out[g]),
      .out_valid(out_valid[g]), .out_lsb(out_lsb[g]), .sat(sat[g]), .loaded(loaded[g])
    );
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: coefficient list and sample history as queues, newest first.
  typedef struct { int cyc; bit lsb; int acc; } exp_t;
  exp_t q[$];
  int   m_coef[$];
  int   m_hist[$];
  bit   m_loaded, m_lsb_mode, m_lsb_pending;
  int   m_cfg_seen, m_coefs_seen, m_acc;

  function automatic void model_reset();
    m_coef = {};
    m_hist = {};
    for (int i = 0; i < N; i++)     m_coef.push_back(0);
    for (int i = 0; i < N - 1; i++) m_hist.push_back(0);
    m_loaded = 0; m_lsb_mode = 0; m_lsb_pending = 0;
    m_cfg_seen = 0; m_coefs_seen = 0; m_acc = 0;
  endfunction

  function automatic int exp_y(int acc, bit lsb, int sh);
    int v;
    if (lsb) return int'($signed(8'(acc)));
    v = acc >>> sh;
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int exp_sat(int acc, bit lsb, int sh);
    int v;
    v = acc >>> sh;
    return (!lsb && (v > 127 || v < -128)) ? 1 : 0;
  endfunction

  // One clock cycle of stimulus; the model decides the outcome from the pre-edge inputs.
  task automatic step(bit cl, bit iv, int d);
    exp_t e;
    int   acc;
    coef_load = cl; in_valid = iv; data_in = 6'(d);
    #1;
    check("in_ready", int'(in_ready[0]), int'(!m_lsb_pending));
    check("loaded", int'(loaded[0]), int'(m_loaded));
    e.cyc = cyc + 1;
    if (cl) begin
      m_loaded = 0; m_lsb_pending = 0; m_cfg_seen = 0; m_coefs_seen = 0;
    end else if (m_lsb_pending) begin
      e.lsb = 1; e.acc = m_acc; q.push_back(e);
      m_lsb_pending = 0;
    end else if (!m_loaded) begin
      if (iv) begin
        if (!m_cfg_seen) begin
          m_lsb_mode = d[0]; m_cfg_seen = 1;
        end else begin
          m_coef.push_front(d); void'(m_coef.pop_back());
          m_coefs_seen++;
          if (m_coefs_seen == N) begin
            foreach (m_hist[i]) m_hist[i] = 0;
            m_loaded = 1; m_cfg_seen = 0; m_coefs_seen = 0;
          end
        end
      end
    end else if (iv) begin
      acc = m_coef[0] * d;
      for (int i = 1; i < N; i++) acc += m_coef[i] * m_hist[i-1];
      e.lsb = 0; e.acc = acc; q.push_back(e);
      m_hist.push_front(d); void'(m_hist.pop_back());
      m_acc = acc;
      if (m_lsb_mode) m_lsb_pending = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(int cfg, int c0, int c1, int c2, int c3);
    step(1, 0, 0);
    step(0, 1, cfg);
    step(0, 1, c0); step(0, 1, c1); step(0, 1, c2); step(0, 1, c3);
  endtask

  task automatic check_reset_outputs();
    for (int g = 0; g < 3; g++) begin
      check($sformatf("rst_y_out[sh%0d]", SHIFTS[g]), int'(y_out[g]), 0);
      check($sformatf("rst_out_valid[sh%0d]", SHIFTS[g]), int'(out_valid[g]), 0);
      check($sformatf("rst_out_lsb[sh%0d]", SHIFTS[g]), int'(out_lsb[g]), 0);
      check($sformatf("rst_sat[sh%0d]", SHIFTS[g]), int'(sat[g]), 0);
      check($sformatf("rst_in_ready[sh%0d]", SHIFTS[g]), int'(in_ready[g]), 1);
      check($sformatf("rst_loaded[sh%0d]", SHIFTS[g]), int'(loaded[g]), 0);
    end
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset();
    coef_load = 0; in_valid = 0;
    @(negedge clk);
    #2 reset_n = 0;
    #1 check_reset_outputs();
    model_reset();
    q.delete();
    #1 reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   due;
    due = (q.size() > 0) && (q[0].cyc <= cyc);
    for (int g = 0; g < 3; g++)
      if (out_valid[g] || due)
        check($sformatf("out_valid[sh%0d]", SHIFTS[g]), int'(out_valid[g]), int'(due));
    if (due) begin
      e = q.pop_front();
      for (int g = 0; g < 3; g++) begin
        check($sformatf("y_out[sh%0d]", SHIFTS[g]), int'(y_out[g]), exp_y(e.acc, e.lsb, SHIFTS[g]));
        check($sformatf("out_lsb[sh%0d]", SHIFTS[g]), int'(out_lsb[g]), int'(e.lsb));
        check($sformatf("sat[sh%0d]", SHIFTS[g]), int'(sat[g]), exp_sat(e.acc, e.lsb, SHIFTS[g]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #3 check_reset_outputs();
    #19 reset_n = 1;
    @(posedge clk);
    #1;

    // Impulse response
    load(0, -32, 16, 8, 4);
    step(0, 1, 16);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    step(0, 0, 0);

    // Saturation both ways
    load(0, -32, -32, -32, -32);
    for (int i = 0; i < 4; i++) step(0, 1, -32);
    for (int i = 0; i < 4; i++) step(0, 1, 31);
    step(0, 0, 0);

    // LSB mode, including a sample offered while the LSB beat is pending
    load(1, 1, 1, 1, 1);
    step(0, 1, 5);
    step(0, 1, 9);
    step(0, 1, 3);
    step(0, 0, 0);
    step(0, 0, 0);

    // Reload while an LSB beat is pending
    load(1, 1, 1, 1, 1);
    step(0, 1, 5);
    step(1, 0, 0);
    step(0, 0, 0);
    load(0, 0, 0, 0, 1);
    step(0, 1, 7);
    step(0, 0, 0);

    // Handshake gaps in RUN
    load(0, 3, -2, 5, 1);
    step(0, 1, 10);
    step(0, 0, -5);
    step(0, 0, 20);
    step(0, 1, -7);
    step(0, 1, 2);
    step(0, 0, 0);

    // Async reset mid-LOAD, then an impulse without a coefficient reload
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 4);
    async_reset();
    for (int r = 0; r < 2; r++) begin
      step(0, 1, 16);
      for (int i = 0; i < 4; i++) step(0, 1, 0);
    end
    step(0, 0, 0);

    // Async reset mid-LSB
    load(1, 2, 3, 4, 5);
    step(0, 1, 9);
    async_reset();
    step(0, 1, 16);
    for (int i = 0; i < 4; i++) step(0, 1, 0);

    // Randomised traffic with occasional reloads and resets
    for (int i = 0; i < 1500; i++) begin
      if (i == 500 || i == 1000) async_reset();
      step($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, 63)) - 32);
    end

    for (int i = 0; i < 3; i++) step(0, 0, 0);
    check("pending_beats", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
